// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared types and helpers for the FIFO stream adapter
//
// Purpose:
//   Shared definitions for fifo_stream_adapter and its output buffer.
//   - DEF_DATA_WIDTH : default word width, matching the upstream sync_fifo
//   - occ_t          : output buffer occupancy (0..2)
//   - beat_w()       : width of the in-burst beat counter for a given burst length
//
// Optional feature macro used elsewhere in this slice: FIFO_STREAM_CSUM_EN

package fifo_stream_pkg;

  localparam int DEF_DATA_WIDTH = 32;

  typedef logic [1:0] occ_t;

  // A burst length of 1 still needs a 1-bit counter so the port/logic
  // widths never collapse to zero.
  function automatic int beat_w(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// rtl/fifo_stream_skid.sv - 2-entry in-order output buffer for the stream adapter
//
// Purpose:
//   Holds up to two words between the FIFO read port and the output stream.
//   Entry 0 is always the head; entry 1 is only meaningful when occ == 2.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset, empties the buffer
//   push       in   write push_data at the end of this cycle
//   push_data  in   word to store
//   pop        in   remove the head at the end of this cycle
//   head_data  out  head word (entry 0)
//   head_valid out  buffer is non-empty
//   occ        out  number of stored words (0..2)

module fifo_stream_skid
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] ent0;
  logic [DATA_WIDTH-1:0] ent1;
  occ_t                  occ_q;

  logic pop_ok;
  logic push_ok;

  // Guard against a pop on an empty buffer or a push into a full one that
  // is not freed by a simultaneous pop. The read-issue logic upstream never
  // produces either, so these only keep the storage self-consistent.
  assign pop_ok  = pop & (occ_q != 2'd0);
  assign push_ok = push & ((occ_q != 2'd2) | pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      ent0  <= '0;
      ent1  <= '0;
      occ_q <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (occ_q == 2'd0) begin
            ent0 <= push_data;
          end else begin
            ent1 <= push_data;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever
          // remains after the head leaves.
          if (occ_q == 2'd2) begin
            ent0 <= ent1;
            ent1 <= push_data;
          end else begin
            ent0 <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head_data  = ent0;
  assign head_valid = (occ_q != 2'd0);
  assign occ        = occ_q;

endmodule

// File: rtl/fifo_stream_adapter.sv
// rtl/fifo_stream_adapter.sv - drains a sync_fifo into a valid/ready stream with burst framing
//
// Purpose:
//   Owns the FIFO read port, hides its one-cycle read latency behind a
//   2-entry output buffer, and tags every BURST_LEN-th delivered word with
//   m_last. With FIFO_STREAM_CSUM_EN defined, an XOR checksum of each burst
//   is presented on m_csum with a one-cycle m_csum_valid strobe.
//
// Ports:
//   clk           in   single clock
//   reset         in   synchronous active-high reset (shared with the FIFO)
//   fifo_dout     in   FIFO read data, valid the cycle after fifo_read_en
//   fifo_empty    in   FIFO empty flag
//   fifo_read_en  out  FIFO pop request
//   m_data        out  output word
//   m_valid       out  output word valid
//   m_last        out  final word of a burst, qualified by m_valid
//   m_ready       in   downstream accept
//   m_csum        out  burst XOR checksum       (FIFO_STREAM_CSUM_EN only)
//   m_csum_valid  out  one-cycle checksum strobe (FIFO_STREAM_CSUM_EN only)

module fifo_stream_adapter
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
`ifdef FIFO_STREAM_CSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] m_csum,
  output logic                  m_csum_valid
`endif
);

  localparam int             BW       = beat_w(BURST_LEN);
  localparam logic [BW-1:0]  BEAT_MAX = BW'(BURST_LEN - 1);

  logic          pend;
  logic [BW-1:0] beat;
  logic [1:0]    occ;
  logic          pop;
  logic [2:0]    committed;

  assign pop = m_valid & m_ready;

  // Words already owned by the adapter: buffered plus the one in flight.
  // A new read may only go out if its word is guaranteed a slot when it
  // returns next cycle, counting the slot freed by this cycle's pop.
  assign committed    = {1'b0, occ} + {2'b00, pend};
  assign fifo_read_en = !reset && !fifo_empty && (committed < (3'd2 + {2'b00, pop}));

  // pend tracks the FIFO's read latency: the word requested this cycle is
  // on fifo_dout next cycle, regardless of what fifo_empty says then.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
    end else begin
      pend <= fifo_read_en;
    end
  end

  fifo_stream_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (pend),
    .push_data  (fifo_dout),
    .pop        (pop),
    .head_data  (m_data),
    .head_valid (m_valid),
    .occ        (occ)
  );

  // Burst position advances only on delivered words, so backpressure never
  // shifts the framing.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat <= '0;
    end else if (pop) begin
      if (beat == BEAT_MAX) begin
        beat <= '0;
      end else begin
        beat <= beat + BW'(1);
      end
    end
  end

  assign m_last = m_valid & (beat == BEAT_MAX);

`ifdef FIFO_STREAM_CSUM_EN
  logic [DATA_WIDTH-1:0] csum_acc;

  // The accumulator holds the XOR of the words popped so far in the current
  // burst; the closing word is folded in directly when loading m_csum.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_acc     <= '0;
      m_csum       <= '0;
      m_csum_valid <= 1'b0;
    end else begin
      m_csum_valid <= 1'b0;
      if (pop) begin
        if (m_last) begin
          m_csum       <= csum_acc ^ m_data;
          m_csum_valid <= 1'b1;
          csum_acc     <= '0;
        end else begin
          csum_acc <= csum_acc ^ m_data;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// tb/tb_fifo_stream_adapter.sv - directed self-checking bench for fifo_stream_adapter

module tb_fifo_stream_adapter;

  localparam int DW = 32;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_read_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
`ifdef FIFO_STREAM_CSUM_EN
  logic [DW-1:0] m_csum;
  logic          m_csum_valid;
`endif

  always #5 clk = ~clk;

  fifo_stream_adapter #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_read_en (fifo_read_en),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready)
`ifdef FIFO_STREAM_CSUM_EN
    ,
    .m_csum       (m_csum),
    .m_csum_valid (m_csum_valid)
`endif
  );

  // Behavioural sync_fifo: registered empty flag, one-cycle read latency.
  logic          hold_fifo;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] fq[$];

  always @(posedge clk) begin
    if (reset && !hold_fifo) begin
      fq.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_read_en && fq.size() != 0) fifo_dout <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Record every delivered word, read pulse and checksum strobe.
  int          cyc = 0;
  int          rd_cnt = 0;
  logic [DW-1:0] rx_d[$];
  logic        rx_l[$];
  int          rx_c[$];
  logic [DW-1:0] cs_v[$];
  int          cs_c[$];

  always @(posedge clk) begin
    if (!reset) begin
      if (m_valid && m_ready) begin
        rx_d.push_back(m_data);
        rx_l.push_back(m_last);
        rx_c.push_back(cyc);
      end
      if (fifo_read_en) rd_cnt <= rd_cnt + 1;
`ifdef FIFO_STREAM_CSUM_EN
      if (m_csum_valid) begin
        cs_v.push_back(m_csum);
        cs_c.push_back(cyc);
      end
`endif
    end
    cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_rx(input string tag, input int target, input int budget);
    for (int k = 0; k < budget && rx_d.size() < target; k++) @(negedge clk);
    chk(tag, rx_d.size(), target);
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_pulse_valid", m_valid, 1'b0);
    chk("reset_pulse_rden", fifo_read_en, 1'b0);
    reset = 1'b0;
  endtask

  logic [DW-1:0] ex [0:15];
  int base;
  int rd0;
  int cbase;

  initial begin
    reset = 1'b1; hold_fifo = 1'b1; wr_en = 1'b0; wr_data = '0; m_ready = 1'b0;
    ex[0] = $urandom; ex[1] = $urandom;
    repeat (2) @(negedge clk);

    // Reset with a non-empty FIFO, then first-word latency.
    @(negedge clk); wr_en = 1'b1; wr_data = ex[0];
    @(negedge clk); wr_data = ex[1];
    @(negedge clk); wr_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_valid", m_valid, 1'b0);
      chk("rst_last", m_last, 1'b0);
      chk("rst_data", m_data, '0);
      chk("rst_rden", fifo_read_en, 1'b0);
`ifdef FIFO_STREAM_CSUM_EN
      chk("rst_csum", m_csum, '0);
      chk("rst_csum_valid", m_csum_valid, 1'b0);
`endif
    end
    reset = 1'b0; hold_fifo = 1'b0;
    #1;
    chk("lat_rden_c0", fifo_read_en, 1'b1);
    chk("lat_valid_c0", m_valid, 1'b0);
    @(negedge clk);
    chk("lat_valid_c1", m_valid, 1'b0);
    @(negedge clk);
    chk("lat_valid_c2", m_valid, 1'b1);
    chk("lat_data_c2", m_data, ex[0]);
    m_ready = 1'b1;
    @(negedge clk);
    chk("lat_data_c3", m_data, ex[1]);
    @(negedge clk);
    chk("lat_drained", m_valid, 1'b0);

    // Streaming: 8 words, one burst, back-to-back.
    do_reset();
    m_ready = 1'b1;
    base = rx_d.size();
    for (int i = 0; i < 8; i++) begin
      ex[i] = $urandom;
      @(negedge clk); wr_en = 1'b1; wr_data = ex[i];
    end
    @(negedge clk); wr_en = 1'b0;
    wait_rx("stream_count", base + 8, 40);
    for (int i = 0; i < 8 && base + i < rx_d.size(); i++) begin
      chk($sformatf("stream_data%0d", i), rx_d[base+i], ex[i]);
      chk($sformatf("stream_last%0d", i), rx_l[base+i], (i == 7));
      if (i > 0) chk($sformatf("stream_gap%0d", i), rx_c[base+i] - rx_c[base+i-1], 1);
    end

    // Backpressure: 4 words, m_ready low for 10 cycles.
    do_reset();
    m_ready = 1'b0;
    rd0 = rd_cnt;
    base = rx_d.size();
    for (int i = 0; i < 4; i++) begin
      ex[i] = $urandom;
      @(negedge clk); wr_en = 1'b1; wr_data = ex[i];
    end
    @(negedge clk); wr_en = 1'b0;
    repeat (10) @(negedge clk);
    chk("bp_reads", rd_cnt - rd0, 2);
    chk("bp_valid", m_valid, 1'b1);
    chk("bp_head", m_data, ex[0]);
    chk("bp_rden_low", fifo_read_en, 1'b0);
    repeat (3) @(negedge clk);
    chk("bp_head_stable", m_data, ex[0]);
    m_ready = 1'b1;
    #1;
    chk("bp_restart_rden", fifo_read_en, 1'b1);
    wait_rx("bp_count", base + 4, 20);
    for (int i = 0; i < 4 && base + i < rx_d.size(); i++) begin
      chk($sformatf("bp_data%0d", i), rx_d[base+i], ex[i]);
      if (i > 0) chk($sformatf("bp_gap%0d", i), rx_c[base+i] - rx_c[base+i-1], 1);
    end

    // Toggling ready: 16 words, two bursts.
    do_reset();
    base = rx_d.size();
    for (int i = 0; i < 16; i++) ex[i] = $urandom;
    for (int i = 0; i < 120 && rx_d.size() < base + 16; i++) begin
      @(negedge clk);
      m_ready = (i % 2 == 0);
      wr_en = (i < 16);
      if (i < 16) wr_data = ex[i];
    end
    @(negedge clk); wr_en = 1'b0; m_ready = 1'b1;
    chk("tog_count", rx_d.size(), base + 16);
    for (int i = 0; i < 16 && base + i < rx_d.size(); i++) begin
      chk($sformatf("tog_data%0d", i), rx_d[base+i], ex[i]);
      chk($sformatf("tog_last%0d", i), rx_l[base+i], (i == 7 || i == 15));
    end

`ifdef FIFO_STREAM_CSUM_EN
    // Checksum: burst 1..8 gives 0x8; next burst 0x1 then zeros gives 0x1.
    do_reset();
    m_ready = 1'b1;
    base = rx_d.size();
    cbase = cs_v.size();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); wr_en = 1'b1;
      wr_data = (i < 8) ? DW'(i + 1) : ((i == 8) ? DW'(1) : '0);
    end
    @(negedge clk); wr_en = 1'b0;
    wait_rx("cs_count", base + 16, 50);
    repeat (3) @(negedge clk);
    chk("cs_strobes", cs_v.size(), cbase + 2);
    if (cs_v.size() >= cbase + 2 && rx_c.size() >= base + 16) begin
      chk("cs_burst1", cs_v[cbase], 32'h0000_0008);
      chk("cs_burst1_cycle", cs_c[cbase] - rx_c[base+7], 1);
      chk("cs_burst2", cs_v[cbase+1], 32'h0000_0001);
      chk("cs_burst2_cycle", cs_c[cbase+1] - rx_c[base+15], 1);
    end
    chk("cs_strobe_low", m_csum_valid, 1'b0);
`endif

    // Reset mid-burst after 3 pops.
    do_reset();
    m_ready = 1'b0;
    base = rx_d.size();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = $urandom;
    end
    @(negedge clk); wr_en = 1'b0;
    repeat (3) @(negedge clk);
    m_ready = 1'b1;
    for (int k = 0; k < 30 && rx_d.size() < base + 3; k++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_valid", m_valid, 1'b0);
    chk("mid_popped", rx_d.size(), base + 3);
    reset = 1'b0;
    base = rx_d.size();
    for (int i = 0; i < 8; i++) begin
      ex[i] = $urandom;
      @(negedge clk); wr_en = 1'b1; wr_data = ex[i];
    end
    @(negedge clk); wr_en = 1'b0;
    wait_rx("mid_count", base + 8, 40);
    for (int i = 0; i < 8 && base + i < rx_d.size(); i++) begin
      chk($sformatf("mid_data%0d", i), rx_d[base+i], ex[i]);
      chk($sformatf("mid_last%0d", i), rx_l[base+i], (i == 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
